gfx256_wbs_tex: RTL and testbench
=================================

# gfx256_wbs_tex

Wishbone responder that serves 256-bit requests from the graphics accelerator's texture read/write initiator out of a local byte-lane-writable texture RAM. It accepts classic single-beat `wb_cmd_request256_t` cycles and returns `wb_cmd_response256_t` with the requester's `tid` echoed. It has a configurable read-pipeline latency and signals an error for addresses outside its window. It sits on the texture bus opposite the accelerator's bus master, as a simulation and FPGA-local texture store.

## Interface
- `ADR_BASE`, default 32'h4000_0000: byte address of RAM entry 0; must be 32-byte aligned.
- `DEPTH`, default 1024: number of 256-bit entries; power of two; range is 2..65536.
- `RD_LAT`, default 2: read latency in RAM pipeline stages; legal values 1..3.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset; one clock; reset is asynchronous and active-high.
- `wbs_req`, in, `wb_cmd_request256_t`: request from the initiator. Fields used are `cyc`, `stb`, `we`, `sel[31:0]`, `padr[31:0]`, `dat[255:0]` and `tid`.
- `wbs_resp`, out, `wb_cmd_response256_t`: response carrying `ack`, `err`, `rty`, `tid` and `dat[255:0]`.
- `busy_o`, out, 1: high in any state other than IDLE.
- `err_cnt_o`, out, 16: count of error responses; saturates at 16'hFFFF.

## Operation
- **Address decode:**
  - `idx = (padr - ADR_BASE) >> 5`.
  - `padr[4:0]` is ignored.
  - The request is in range iff `padr >= ADR_BASE` and `idx < DEPTH`.
  - The subtraction is 32-bit unsigned; any borrow means out of range.
- **State machine:** IDLE, RD_WAIT, RESP, WAIT_END.
- **IDLE:**
  - A request is accepted when `cyc & stb` is high.
  - Out of range: go to RESP with `err` = 1. RAM is untouched and `err_cnt_o` increments.
  - Write: for each `i` with `sel[i]` = 1, byte `dat[8i+7:8i]` is written at `idx` on the accept edge. Then go to RESP with `ack` = 1.
    - `sel` = 0 still acks and writes nothing.
  - Read: the RAM read is issued at `idx`. If `RD_LAT` = 1, go to RESP; otherwise go to RD_WAIT with `cnt = RD_LAT-1`.
- **RD_WAIT:** decrement `cnt`; when `cnt` reaches 1, go to RESP with `ack` = 1 and `dat` = RAM output.
  - If `cyc` drops while in RD_WAIT (abort), return to IDLE with no response.
- **RESP:**
  - `ack` or `err` is high for exactly one cycle.
  - `tid` is the value latched at accept.
  - `dat` is the read data; it is zero for writes and errors.
  - Next state is WAIT_END.
- **WAIT_END:** return to IDLE when `!(cyc & stb)`.
  - A request held across the response is never acked twice.
  - The initiator clears its request on the edge it samples `ack`, so WAIT_END normally lasts one cycle.
- `rty` is always 0.
- **Reset values:**
  - All `wbs_resp` fields are 0; `busy_o` = 0; `err_cnt_o` = 0; state is IDLE.
  - RAM contents are not cleared.
  - Reset mid-transaction drops the transaction without a response.

## Timing
- Acceptance edge is E0, the first edge with `cyc & stb` in IDLE.
- Write and error: `ack`/`err` are visible in the cycle after E0.
- Read: `ack` is visible `RD_LAT` cycles after E0, with data valid in the same cycle.
- Back-to-back: the earliest next acceptance is 2 cycles after the response cycle (WAIT_END, then IDLE).
- A read issued after a write to the same `idx` returns the new data, because the write completes at its E0.
- All outputs are registered; there is no combinational path from `wbs_req` to `wbs_resp`.

## Structure
- `wishbone_pkg` supplies `wb_cmd_request256_t` and `wb_cmd_response256_t`.
- `gfx256_pkg` gains:
  - `GFX_TEX_ADR_BASE`, default value for `ADR_BASE`;
  - `gfx_tex_state_t`, the state enum.
- Sub-module `gfx256_tex_ram` holds the RAM:
  - single port, 256-bit wide, 32 byte-write enables;
  - `RD_LAT`-stage registered read pipeline;
  - ports: `clk_i`, `we`, `sel`, `adr`, `din`, `dout`.

## Test plan
Defaults unless stated: `ADR_BASE` 0x4000_0000, `DEPTH` 1024, `RD_LAT` 2.
- Write `sel` 32'hFFFF_FFFF with data 256'h0123…EF at 0x4000_0020 (`tid` 0x51), then read 0x4000_0020.
  - Write: ack 1 cycle after accept, `dat` 0.
  - Read: ack 2 cycles after accept with data equal to the written value and `tid` echoed.
- Partial write `sel` 32'h0000_000F with data 0xDEADBEEF at 0x4000_0020, then read.
  - Bits [31:0] = 0xDEADBEEF; bits [255:32] unchanged.
- Read 0x3FFF_FFE0 and then 0x4000_8000.
  - Each returns `err` = 1 and `ack` = 0; `err_cnt_o` = 2; RAM unchanged.
- Hold `cyc`/`stb` high for 4 cycles after ack.
  - Exactly one `ack` pulse; `busy_o` stays high until `stb` drops.
- Drop `cyc` 1 cycle into a read; also assert `rst_i` during a later RD_WAIT.
  - No `ack` in either case; state returns to IDLE.
  - After reset, all outputs are 0, and a prior write is still readable.
- With `RD_LAT` = 1 and 3, read a known entry.
  - Ack 1 and 3 cycles after accept respectively.

Source files
------------

// File: rtl/gfx256_pkg.sv
// Graphics accelerator shared constants and the texture responder state type.
package gfx256_pkg;

  localparam logic [31:0] GFX_TEX_ADR_BASE = 32'h4000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StResp,
    StWaitEnd
  } gfx_tex_state_t;

endpackage

// File: rtl/wishbone_pkg.sv
// Wishbone 256-bit command request/response types shared by texture bus agents.
package wishbone_pkg;

  typedef logic [7:0] wb_tid_t;

  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic [31:0]   sel;
    logic [31:0]   padr;
    logic [255:0]  dat;
    wb_tid_t       tid;
  } wb_cmd_request256_t;

  typedef struct packed {
    logic          ack;
    logic          err;
    logic          rty;
    wb_tid_t       tid;
    logic [255:0]  dat;
  } wb_cmd_response256_t;

endpackage

// File: rtl/gfx256_wbs_tex_if.sv
// Texture bus: request from the initiator, response from the responder.
interface gfx256_wbs_tex_if;
  import wishbone_pkg::*;

  wb_cmd_request256_t  wbs_req;
  wb_cmd_response256_t wbs_resp;

  modport master (output wbs_req, input wbs_resp);
  modport slave  (input wbs_req, output wbs_resp);
endinterface

// File: rtl/gfx256_tex_ram.sv
// Single-port 256-bit texture RAM with byte-lane writes and an RD_LAT-stage read pipeline.
module gfx256_tex_ram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           we,
  input  logic [31:0]    sel,
  input  logic [AW-1:0]  adr,
  input  logic [255:0]   din,
  output logic [255:0]   dout
);

  logic [255:0] mem_q  [DEPTH];
  logic [255:0] pipe_q [RD_LAT];

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int i = 0; i < 32; i++) begin
        if (sel[i]) mem_q[adr][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_q[0] <= mem_q[adr];
    for (int s = 1; s < RD_LAT; s++) begin
      pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign dout = pipe_q[RD_LAT-1];

endmodule

// File: rtl/gfx256_wbs_tex.sv
// Wishbone responder serving single-beat 256-bit texture reads/writes from a local RAM.
module gfx256_wbs_tex
  import wishbone_pkg::*;
  import gfx256_pkg::*;
#(
  parameter logic [31:0] ADR_BASE = GFX_TEX_ADR_BASE,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  gfx256_wbs_tex_if.slave    wbs,
  output logic               busy_o,
  output logic [15:0]        err_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  gfx_tex_state_t state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic           rd_q, rd_d;
  wb_tid_t        tid_q, tid_d;
  logic [15:0]    err_cnt_q, err_cnt_d;

  logic [31:0]    off;
  logic [31:0]    idx_full;
  logic           in_range;
  logic           accept;
  logic           ram_we;
  logic [255:0]   ram_dout;
  wb_cmd_response256_t resp;

  // A borrow in the subtraction shows up as padr < ADR_BASE.
  assign off      = wbs.wbs_req.padr - ADR_BASE;
  assign idx_full = off >> 5;
  assign in_range = (wbs.wbs_req.padr >= ADR_BASE) && (idx_full < DEPTH);
  assign accept   = (state_q == StIdle) && wbs.wbs_req.cyc && wbs.wbs_req.stb;
  assign ram_we   = accept && in_range && wbs.wbs_req.we;

  gfx256_tex_ram #(
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk_i (clk_i),
    .we    (ram_we),
    .sel   (wbs.wbs_req.sel),
    .adr   (idx_full[AW-1:0]),
    .din   (wbs.wbs_req.dat),
    .dout  (ram_dout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      tid_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      tid_q     <= tid_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!in_range || wbs.wbs_req.we || (RD_LAT == 1)) begin
            state_d = StResp;
          end else begin
            state_d = StRdWait;
            cnt_d   = 2'(RD_LAT - 1);
          end
        end
      end
      StRdWait: begin
        if (!wbs.wbs_req.cyc) begin
          state_d = StIdle;
        end else if (cnt_q == 2'd1) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp:    state_d = StWaitEnd;
      StWaitEnd: if (!(wbs.wbs_req.cyc && wbs.wbs_req.stb)) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rd_d      = rd_q;
    tid_d     = tid_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      tid_d = wbs.wbs_req.tid;
      rd_d  = in_range && !wbs.wbs_req.we;
      if (!in_range) begin
        err_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end else if (wbs.wbs_req.we || (RD_LAT == 1)) begin
        ack_d = 1'b1;
      end
    end
    if ((state_q == StRdWait) && wbs.wbs_req.cyc && (cnt_q == 2'd1)) ack_d = 1'b1;
  end

  // Read data is taken straight from the RAM's output register during the response cycle.
  always_comb begin
    resp     = '0;
    resp.ack = ack_q;
    resp.err = err_q;
    resp.tid = tid_q;
    resp.dat = (ack_q && rd_q) ? ram_dout : '0;
  end

  assign wbs.wbs_resp = resp;
  assign busy_o       = (state_q != StIdle);
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_gfx256_wbs_tex.sv
// Randomized self-checking bench: three responders (RD_LAT 1/2/3) share one request bus.
module tb_gfx256_wbs_tex;
  import wishbone_pkg::*;
  import gfx256_pkg::*;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_cmd_request256_t req;
  gfx256_wbs_tex_if bus1 ();
  gfx256_wbs_tex_if bus2 ();
  gfx256_wbs_tex_if bus3 ();
  assign bus1.wbs_req = req;
  assign bus2.wbs_req = req;
  assign bus3.wbs_req = req;

  logic        busy1, busy2, busy3;
  logic [15:0] ec1, ec2, ec3;

  gfx256_wbs_tex #(.ADR_BASE(BASE), .DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .wbs(bus1), .busy_o(busy1), .err_cnt_o(ec1));
  gfx256_wbs_tex #(.ADR_BASE(BASE), .DEPTH(DEPTH), .RD_LAT(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .wbs(bus2), .busy_o(busy2), .err_cnt_o(ec2));
  gfx256_wbs_tex #(.ADR_BASE(BASE), .DEPTH(DEPTH), .RD_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .wbs(bus3), .busy_o(busy3), .err_cnt_o(ec3));

  logic [255:0] mdl [int];
  int           known[$];
  int           exp_ec;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           resp_n [4] = '{0, 0, 0, 0};

  // Counts response pulses (ack or err) of each responder.
  always @(negedge clk) begin
    resp_n[1] += int'(bus1.wbs_resp.ack | bus1.wbs_resp.err);
    resp_n[2] += int'(bus2.wbs_resp.ack | bus2.wbs_resp.err);
    resp_n[3] += int'(bus3.wbs_resp.ack | bus3.wbs_resp.err);
  end

  function automatic wb_cmd_response256_t resp_of(input int d);
    case (d)
      1:       return bus1.wbs_resp;
      3:       return bus3.wbs_resp;
      default: return bus2.wbs_resp;
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 1) ? busy1 : (d == 3) ? busy3 : busy2;
  endfunction

  function automatic logic [15:0] ec_of(input int d);
    return (d == 1) ? ec1 : (d == 3) ? ec3 : ec2;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input int d);
    wb_cmd_response256_t r;
    r = resp_of(d);
    check_val($sformatf("rst_ack%0d", d), r.ack, 0);
    check_val($sformatf("rst_err%0d", d), r.err, 0);
    check_val($sformatf("rst_tid%0d", d), r.tid, 0);
    check_val($sformatf("rst_dat%0d", d), r.dat, 0);
    check_val($sformatf("rst_busy%0d", d), busy_of(d), 0);
    check_val($sformatf("rst_ec%0d", d), ec_of(d), 0);
  endtask

  // One full transaction observed on responder d; expectations come from the model.
  task automatic txn(input int d, input logic we, input logic [31:0] sel, input logic [31:0] adr,
                     input logic [255:0] dat, input logic [7:0] tid, input int hold);
    longint a, b;
    bit in_r;
    int idx, exp_lat, lat, n0;
    logic [255:0] exp_dat, t;
    wb_cmd_response256_t r;
    a = longint'(adr);
    b = longint'(BASE);
    in_r = (a >= b) && (((a - b) / 32) < DEPTH);
    idx = in_r ? int'((a - b) / 32) : 0;
    exp_lat = (!in_r || we) ? 1 : d;
    exp_dat = (in_r && !we) ? mdl[idx] : '0;
    n0 = resp_n[d];
    @(posedge clk); #1;
    req = '{cyc: 1'b1, stb: 1'b1, we: we, sel: sel, padr: adr, dat: dat, tid: tid};
    @(posedge clk);
    lat = 0;
    r = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      r = resp_of(d);
      if (r.ack || r.err) begin
        lat = k;
        break;
      end
    end
    check_val("latency", lat, exp_lat);
    check_val("ack", r.ack, in_r);
    check_val("err", r.err, !in_r);
    check_val("rty", r.rty, 0);
    check_val("tid", r.tid, tid);
    check_val("dat", r.dat, exp_dat);
    check_val("busy_resp", busy_of(d), 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      r = resp_of(d);
      check_val("no_reack", r.ack | r.err, 0);
      check_val("busy_hold", busy_of(d), 1);
    end
    @(posedge clk); #1;
    req.cyc = 1'b0;
    req.stb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("busy_idle", busy_of(d), 0);
    check_val("resp_count", resp_n[d] - n0, 1);
    if (in_r && we) begin
      t = mdl.exists(idx) ? mdl[idx] : '0;
      for (int i = 0; i < 32; i++) if (sel[i]) t[8*i +: 8] = dat[8*i +: 8];
      mdl[idx] = t;
    end
    if (!in_r && exp_ec < 16'hFFFF) exp_ec++;
    check_val("err_cnt", ec_of(d), exp_ec);
  endtask

  initial begin
    logic [255:0] pat;
    int n2, n3, op, d, ix;
    logic [31:0] adr;
    req = '0;
    exp_ec = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 1; i <= 3; i++) check_idle_outputs(i);
    rst = 1'b0;

    pat = {4{64'h0123_4567_89AB_CDEF}};
    txn(2, 1'b1, 32'hFFFF_FFFF, 32'h4000_0020, pat, 8'h51, 0);
    known.push_back(1);
    txn(2, 1'b0, 32'h0, 32'h4000_0020, '0, 8'h51, 0);
    txn(2, 1'b1, 32'h0000_000F, 32'h4000_0020, {224'h0, 32'hDEAD_BEEF}, 8'h52, 0);
    txn(2, 1'b0, 32'h0, 32'h4000_0020, '0, 8'h53, 0);
    txn(2, 1'b1, 32'h0, 32'h4000_0020, rand256(), 8'h54, 0);
    txn(2, 1'b0, 32'h0, 32'h4000_0020, '0, 8'h55, 0);
    txn(2, 1'b0, 32'h0, 32'h3FFF_FFE0, '0, 8'h60, 0);
    txn(2, 1'b0, 32'h0, 32'h4000_8000, '0, 8'h61, 0);
    txn(2, 1'b0, 32'h0, 32'h4000_0020, '0, 8'h62, 0);
    txn(2, 1'b0, 32'h0, 32'h4000_0020, '0, 8'h63, 4);
    txn(3, 1'b1, 32'hFFFF_FFFF, 32'h4000_7FE0, rand256(), 8'h70, 4);
    known.push_back(DEPTH - 1);
    txn(2, 1'b0, 32'h0, 32'h4000_7FFF, '0, 8'h71, 0);
    txn(2, 1'b1, 32'hFFFF_FFFF, 32'h4000_001F, rand256(), 8'h72, 0);
    known.push_back(0);
    txn(1, 1'b0, 32'h0, 32'h4000_0000, '0, 8'h73, 0);
    txn(3, 1'b0, 32'h0, 32'h4000_0020, '0, 8'h74, 0);

    // Abort: cyc drops the cycle after acceptance.
    n2 = resp_n[2];
    n3 = resp_n[3];
    @(posedge clk); #1;
    req = '{cyc: 1'b1, stb: 1'b1, we: 1'b0, sel: 32'h0, padr: 32'h4000_0020, dat: '0, tid: 8'h80};
    @(posedge clk); #1;
    req.cyc = 1'b0;
    repeat (4) @(negedge clk);
    check_val("abort_resp2", resp_n[2] - n2, 0);
    check_val("abort_resp3", resp_n[3] - n3, 0);
    check_val("abort_busy2", busy2, 0);
    check_val("abort_busy3", busy3, 0);
    req.stb = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while responders 2 and 3 wait on the read pipeline.
    n2 = resp_n[2];
    n3 = resp_n[3];
    @(posedge clk); #1;
    req = '{cyc: 1'b1, stb: 1'b1, we: 1'b0, sel: 32'h0, padr: 32'h4000_0020, dat: '0, tid: 8'h81};
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    req = '0;
    @(negedge clk); #1;
    rst = 1'b0;
    exp_ec = 0;
    repeat (3) @(negedge clk);
    check_val("rst_resp2", resp_n[2] - n2, 0);
    check_val("rst_resp3", resp_n[3] - n3, 0);
    for (int i = 1; i <= 3; i++) check_idle_outputs(i);
    txn(2, 1'b0, 32'h0, 32'h4000_0020, '0, 8'h82, 0);

    for (int i = 0; i < 8; i++) begin
      ix = $urandom_range(0, DEPTH - 1);
      txn($urandom_range(1, 3), 1'b1, 32'hFFFF_FFFF, BASE + 32'(ix) * 32, rand256(),
          8'($urandom), 0);
      known.push_back(ix);
    end
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      d  = $urandom_range(1, 3);
      ix = known[$urandom_range(0, known.size() - 1)];
      adr = BASE + 32'(ix) * 32 + 32'($urandom_range(0, 31));
      if (op < 4) begin
        txn(d, 1'b1, $urandom, adr, rand256(), 8'($urandom), 0);
      end else if (op < 8) begin
        txn(d, 1'b0, $urandom, adr, rand256(), 8'($urandom), $urandom_range(0, 2));
      end else begin
        if ($urandom_range(0, 1) == 1) adr = $urandom_range(0, BASE - 1);
        else adr = BASE + DEPTH * 32 + $urandom_range(0, 32'h0FFF_FFFF);
        txn(d, op[0], $urandom, adr, rand256(), 8'($urandom), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
